uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: accepts parallel words over a valid/ready handshake and drives them onto a single asynchronous serial line as start bit, data bits LSB first, optional parity, and stop bits. It is the upstream stage of the UART receiver: its `tx` output feeds the receiver's `rx` input, either directly in loopback or through the board pin. A one-word holding register lets the producer queue the next word while the current frame shifts out, so back-to-back frames carry no idle gap.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  single clock. All logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_data`  in  DATA_BITS  word to send. Sampled on the handshake edge.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  holding register is empty. The transfer happens on the edge where `tx_valid`&&`tx_ready`.
- `tx`  out  1  serial line. Idle level is 1. Registered.
- `tx_busy`  out  1  high when a frame is in progress or the holding register is full.

## Operation
- Datapath:
  - Holding register `hold` with flag `hold_full`.
  - Shift register plus a bit counter.
  - Baud counter, 0..CLKS_PER_BIT-1.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, `hold_full`=1: load shifter from `hold`, clear `hold_full`, reset baud counter, go to START. `tx` is driven to 0 on the same edge.
  - START: after CLKS_PER_BIT cycles, go to DATA and drive bit 0.
  - DATA: each CLKS_PER_BIT cycles, shift to the next bit. After bit DATA_BITS-1 completes, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: drive the XOR of the data bits, inverted when `PARITY_ODD`. Lasts CLKS_PER_BIT cycles.
  - STOP: drive 1 for STOP_BITS×CLKS_PER_BIT cycles. Then:
    - if `hold_full`, load and go to START on that same edge (no gap);
    - otherwise go to IDLE.
- Handshake:
  - `tx_ready` = !`hold_full` && !`rst`.
  - On acceptance, `hold`<=`tx_data` and `hold_full`<=1.
  - While `hold_full`=1, `tx_ready`=0 and `tx_data` is ignored.
  - Acceptance and the shifter load never collide, because loading requires `hold_full`=1, which forces `tx_ready`=0.
  - `tx_valid` may be dropped without a transfer; no data is retained.
- `tx_busy` = (state != IDLE) || `hold_full`.
- Reset values while `rst`=1 and on the edge after it:
  - state IDLE, `tx`=1, `hold_full`=0, `tx_busy`=0, counters 0.
  - `tx_ready`=0 while `rst` is high and 1 on the first cycle after release.
- Reset mid-frame: the frame is abandoned and `tx` returns to 1 on the next edge. A queued word in `hold` is discarded. No partial stop bit is emitted.
- Parameter illegal values (CLKS_PER_BIT<2, DATA_BITS outside 5..9, STOP_BITS not 1 or 2) must fail elaboration.

## Timing
- Handshake at edge E0 with the transmitter idle:
  - E0: `hold_full` rises, `tx_ready` falls.
  - E1: FSM loads the shifter, `tx` falls to 0, `hold_full` clears.
  - From the cycle after E1: `tx_ready`=1.
- Latency from handshake edge to the falling start edge on `tx` is 1 clock.
- Frame length is (1+DATA_BITS+PARITY_EN+STOP_BITS)×CLKS_PER_BIT clocks, measured from the start edge to the end of the last stop bit.
- Each bit on `tx` is held for exactly CLKS_PER_BIT cycles. There is no jitter and no stretched bits.
- Back-to-back: if `hold` is refilled before the last stop-bit cycle, the next start bit immediately follows the last stop cycle. The line sees no idle cycles.
- Sustained throughput: one word per frame length. `tx_ready` is low for at most one frame length.

## Test plan
- Reset, then CLKS_PER_BIT=4, 8N1, send 0xA5:
  - `tx` = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks.
  - 40 clocks from the start edge; `tx_busy` falls after the stop bit.
- PARITY_EN=1 with 0xA5:
  - PARITY_ODD=0 gives a parity bit of 0; PARITY_ODD=1 gives 1.
  - Frame length is 44 clocks.
- Back-to-back 0x00 then 0xFF, with `tx_valid` held high:
  - The second word is accepted while the first shifts.
  - 80 contiguous clocks are observed: the stop bit of frame 1 is followed directly by the start bit of frame 2.
- Backpressure: offer 3 words at once.
  - Word 1 goes to the shifter and word 2 fills `hold`.
  - `tx_ready`=0 holds off word 3 until word 2 loads.
  - Three frames appear in order, with no loss or duplication.
- Reset mid-frame: assert `rst` for 1 clock during DATA bit 3 with `hold` full.
  - `tx`=1 on the next edge and stays idle; the queued word is never sent.
  - `tx_ready`=1 after release.
- Loopback: connect `tx` to the receiver's `rx` with STOP_BITS=2.
  - The receiver returns to IDLE after each frame.
  - Random words arrive back intact over 256 frames.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter with a one-word holding register; frames are
//            start, LSB-first data, optional parity, and one or two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int                BAUD_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        C_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        C_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic              C_ODD       = (PARITY_ODD != 0);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state,     w_state_next;
    logic [BAUD_W-1:0]     r_baud,      w_baud_next;
    logic [3:0]            r_bit,       w_bit_next;
    logic [DATA_BITS-1:0]  r_shift,     w_shift_next;
    logic                  r_parity,    w_parity_next;
    logic                  r_tx,        w_tx_next;
    logic [DATA_BITS-1:0]  r_hold,      w_hold_next;
    logic                  r_hold_full, w_hold_full_next;
    logic                  w_tick;
    logic                  w_load;
    logic                  w_accept;

    assign tx_ready = !r_hold_full && !rst;
    assign tx_busy  = (r_state != S_IDLE) || r_hold_full;
    assign tx       = r_tx;
    assign w_tick   = (r_baud == C_BAUD_LAST);
    assign w_accept = tx_valid && tx_ready;

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        w_load        = 1'b0;

        if (r_state != S_IDLE) begin
            w_baud_next = w_tick ? '0 : r_baud + BAUD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (r_hold_full) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == C_DATA_LAST) begin
                        w_bit_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        // shifter[0] is the bit on the line, so [1] is the next one
                        w_bit_next   = r_bit + 4'd1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit == C_STOP_LAST) begin
                        w_bit_next = '0;
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase

        // Parity is computed once at load so the shifter is free to move
        if (w_load) begin
            w_state_next  = S_START;
            w_baud_next   = '0;
            w_bit_next    = '0;
            w_shift_next  = r_hold;
            w_parity_next = (^r_hold) ^ C_ODD;
            w_tx_next     = 1'b0;
        end
    end

    always_comb begin
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        // Load needs hold_full=1, which blocks acceptance, so these never collide
        if (w_load) begin
            w_hold_full_next = 1'b0;
        end else if (w_accept) begin
            w_hold_next      = tx_data;
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_baud      <= w_baud_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_parity    <= w_parity_next;
            r_tx        <= w_tx_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Three uart_tx configurations against a frame-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_next;
    logic [7:0] tdata  [NI];
    logic       tvalid [NI];
    logic       tready [NI];
    logic       txl    [NI];
    logic       tbusy  [NI];

    int cpb   [NI];
    int pen   [NI];
    int podd  [NI];
    int nstop [NI];

    // Model: the frame on the line (word + start cycle) and the held word
    bit         m_act   [NI];
    logic [7:0] m_word  [NI];
    int         m_start [NI];
    bit         m_hv    [NI];
    logic [7:0] m_hw    [NI];
    int         ncyc;

    logic [7:0] sbuf [NI][8];
    int         sh   [NI];
    int         st   [NI];
    bit         rnd_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tdata[0]), .tx_valid(tvalid[0]),
        .tx_ready(tready[0]), .tx(txl[0]), .tx_busy(tbusy[0]));

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tdata[1]), .tx_valid(tvalid[1]),
        .tx_ready(tready[1]), .tx(txl[1]), .tx_busy(tbusy[1]));

    uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tdata[2]), .tx_valid(tvalid[2]),
        .tx_ready(tready[2]), .tx(txl[2]), .tx_busy(tbusy[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int i);
        return (1 + 8 + pen[i] + nstop[i]) * cpb[i];
    endfunction

    // Line level for bit slot idx of a frame carrying w
    function automatic logic frame_bit(input int i, input logic [7:0] w, input int idx);
        logic par;
        par = (^w) ^ podd[i][0];
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (pen[i] != 0 && idx == 9) return par;
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [7:0] w);
        sbuf[i][st[i] % 8] = w;
        st[i]++;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            logic e_tx;
            e_tx = m_act[i] ? frame_bit(i, m_word[i], (ncyc - m_start[i]) / cpb[i]) : 1'b1;
            check_val($sformatf("u%0d tx @%0d", i, ncyc), 32'(txl[i]), 32'(e_tx));
            check_val($sformatf("u%0d ready @%0d", i, ncyc), 32'(tready[i]), 32'(!m_hv[i] && !rst));
            check_val($sformatf("u%0d busy @%0d", i, ncyc), 32'(tbusy[i]), 32'(m_act[i] || m_hv[i]));
        end

        rst = rst_next;
        for (int i = 0; i < NI; i++) begin
            if (rnd_mode) begin
                tvalid[i] = ($urandom_range(0, 3) != 0);
                tdata[i]  = 8'($urandom);
            end else begin
                tvalid[i] = (sh[i] != st[i]);
                tdata[i]  = sbuf[i][sh[i] % 8];
            end
        end

        // Predict the coming edge
        for (int i = 0; i < NI; i++) begin
            bit acc;
            acc = tvalid[i] && !m_hv[i] && !rst;
            if (rst) begin
                m_act[i] = 1'b0;
                m_hv[i]  = 1'b0;
            end else begin
                if (m_act[i] && (ncyc + 1 == m_start[i] + frame_len(i))) m_act[i] = 1'b0;
                if (!m_act[i] && m_hv[i]) begin
                    m_act[i]   = 1'b1;
                    m_start[i] = ncyc + 1;
                    m_word[i]  = m_hw[i];
                    m_hv[i]    = 1'b0;
                end
                if (acc) begin
                    m_hv[i] = 1'b1;
                    m_hw[i] = tdata[i];
                    if (!rnd_mode) sh[i]++;
                end
            end
        end
        ncyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d %s drained", i, tag), 32'(sh[i]), 32'(st[i]));
        end
    endtask

    initial begin
        bit trig;
        cpb   = '{4, 4, 3};
        pen   = '{0, 1, 1};
        podd  = '{0, 0, 1};
        nstop = '{1, 1, 2};
        for (int i = 0; i < NI; i++) begin
            tvalid[i] = 1'b0;
            tdata[i]  = 8'h00;
            m_act[i]  = 1'b0;
            m_hv[i]   = 1'b0;
            m_word[i] = 8'h00;
            m_hw[i]   = 8'h00;
            m_start[i] = 0;
            sh[i]     = 0;
            st[i]     = 0;
        end
        ncyc     = 0;
        rnd_mode = 1'b0;
        rst      = 1'b1;
        rst_next = 1'b1;

        run(3);
        rst_next = 1'b0;
        run(2);

        // Single word 0xA5 on every configuration
        for (int i = 0; i < NI; i++) push(i, 8'hA5);
        run(60);
        check_drained("a5");

        // Back-to-back with valid held high
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h00);
            push(i, 8'hFF);
        end
        run(110);
        check_drained("b2b");

        // Three words offered at once: backpressure on the third
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h11);
            push(i, 8'h22);
            push(i, 8'h33);
        end
        run(160);
        check_drained("bp");

        // Reset during data bit 3 of unit 0 while its holding register is full
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h3C);
            push(i, 8'hC3);
        end
        trig = 1'b0;
        for (int k = 0; k < 200 && !trig; k++) begin
            if (m_act[0] && m_hv[0] && ((ncyc - m_start[0]) / cpb[0] == 4)) trig = 1'b1;
            else step();
        end
        check_val("rst trigger reached", 32'(trig), 32'd1);
        rst_next = 1'b1;
        step();
        for (int i = 0; i < NI; i++) sh[i] = st[i];
        rst_next = 1'b0;
        run(60);

        // Random traffic with occasional resets
        rnd_mode = 1'b1;
        for (int k = 0; k < 14000; k++) begin
            rst_next = ($urandom_range(0, 4999) == 0);
            step();
        end
        rst_next = 1'b0;
        rnd_mode = 1'b0;
        for (int i = 0; i < NI; i++) sh[i] = st[i];
        run(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
